// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_if
// Description : Signal bundle between the raw front-panel inputs and the
//               input conditioner.
//               master : drives the raw switch/button levels, observes the
//                        conditioned outputs (board side / testbench).
//               slave  : consumes the raw levels, produces the conditioned
//                        outputs (input_conditioner).
//   w_raw      raw level switch              (master -> slave)
//   save_raw   raw push-button, high=pressed (master -> slave)
//   n_raw[3:0] raw threshold switches        (master -> slave)
//   w_out      conditioned level             (slave -> master)
//   save_pulse one-clock strobe per press    (slave -> master)
//   n_out[3:0] threshold captured at press   (slave -> master)
//   btn_busy   button FSM not idle           (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface input_conditioner_if;
    logic       w_raw;
    logic       save_raw;
    logic [3:0] n_raw;
    logic       w_out;
    logic       save_pulse;
    logic [3:0] n_out;
    logic       btn_busy;

    modport master (
        output w_raw, save_raw, n_raw,
        input  w_out, save_pulse, n_out, btn_busy
    );

    modport slave (
        input  w_raw, save_raw, n_raw,
        output w_out, save_pulse, n_out, btn_busy
    );
endinterface
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Synchronises and debounces front-panel inputs.
//               - Two-flop synchronisers on every raw input.
//               - Button FSM (IDLE/PRESS_WAIT/HELD/RELEASE_WAIT) producing a
//                 single save_pulse per debounced press and capturing n_raw
//                 into n_out on that same clock.
//               - w_out is the synchronised w_raw, or, when the macro
//                 INPUT_CONDITIONER_W_DEBOUNCE_EN is defined, the output of a
//                 second debouncer using the same DB_CYCLES.
// Parameters  : DB_CYCLES  stable samples needed to accept a change (2..255)
//               CNT_W      debounce counter width (>= clog2(DB_CYCLES+1))
// Ports       : clk        system clock, rising edge
//               rst        asynchronous reset, active low
//               bus        input_conditioner_if.slave (raw in / conditioned out)
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input_conditioner_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_HELD         = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    // The sample that enters a wait state is the first of DB_CYCLES, so the
    // wait state itself must see DB_CYCLES-1 more; the count of those extra
    // samples reaches DB_CYCLES-2 on the last one.
    localparam logic [CNT_W-1:0] c_BTN_LAST = CNT_W'(DB_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic       r_save_s1, r_save_s2;
    logic       r_w_s1,    r_w_s2;
    logic [3:0] r_n_s1,    r_n_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_save_s1 <= 1'b0;
            r_save_s2 <= 1'b0;
            r_w_s1    <= 1'b0;
            r_w_s2    <= 1'b0;
            r_n_s1    <= 4'b0000;
            r_n_s2    <= 4'b0000;
        end else begin
            r_save_s1 <= bus.save_raw;
            r_save_s2 <= r_save_s1;
            r_w_s1    <= bus.w_raw;
            r_w_s2    <= r_w_s1;
            r_n_s1    <= bus.n_raw;
            r_n_s2    <= r_n_s1;
        end
    end

    // ------------------------------------------------------------------
    // Button FSM
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_btn_cnt;
    logic             r_save_pulse;
    logic [3:0]       r_n_out;
    logic [CNT_W-1:0] w_btn_cnt_inc;

    // Saturating increment: the counter holds at its maximum instead of wrapping.
    assign w_btn_cnt_inc = (r_btn_cnt == c_CNT_MAX) ? r_btn_cnt : r_btn_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_btn_cnt    <= '0;
            r_save_pulse <= 1'b0;
            r_n_out      <= 4'b0000;
        end else begin
            r_save_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (r_save_s2) begin
                        r_state   <= c_ST_PRESS_WAIT;
                        r_btn_cnt <= '0;
                    end
                end
                c_ST_PRESS_WAIT: begin
                    if (!r_save_s2) begin
                        r_state   <= c_ST_IDLE;
                        r_btn_cnt <= '0;
                    end else if (r_btn_cnt >= c_BTN_LAST) begin
                        r_state      <= c_ST_HELD;
                        r_btn_cnt    <= '0;
                        r_save_pulse <= 1'b1;
                        r_n_out      <= r_n_s2;
                    end else begin
                        r_btn_cnt <= w_btn_cnt_inc;
                    end
                end
                c_ST_HELD: begin
                    if (!r_save_s2) begin
                        r_state   <= c_ST_RELEASE_WAIT;
                        r_btn_cnt <= '0;
                    end
                end
                c_ST_RELEASE_WAIT: begin
                    if (r_save_s2) begin
                        r_state   <= c_ST_HELD;
                        r_btn_cnt <= '0;
                    end else if (r_btn_cnt >= c_BTN_LAST) begin
                        r_state   <= c_ST_IDLE;
                        r_btn_cnt <= '0;
                    end else begin
                        r_btn_cnt <= w_btn_cnt_inc;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_btn_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.save_pulse = r_save_pulse;
    assign bus.n_out      = r_n_out;
    assign bus.btn_busy   = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------
    // w_out path
    // ------------------------------------------------------------------
`ifdef INPUT_CONDITIONER_W_DEBOUNCE_EN
    // Counts consecutive synchronised samples that disagree with w_out; the
    // DB_CYCLES-th such sample (count already at DB_CYCLES-1) flips w_out.
    localparam logic [CNT_W-1:0] c_W_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_w_out;
    logic [CNT_W-1:0] r_w_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_out <= 1'b0;
            r_w_cnt <= '0;
        end else if (r_w_s2 == r_w_out) begin
            r_w_cnt <= '0;
        end else if (r_w_cnt >= c_W_LAST) begin
            r_w_out <= r_w_s2;
            r_w_cnt <= '0;
        end else if (r_w_cnt != c_CNT_MAX) begin
            r_w_cnt <= r_w_cnt + CNT_W'(1);
        end
    end

    assign bus.w_out = r_w_out;
`else
    // Second synchroniser flop is already a register: glitch-free as is.
    assign bus.w_out = r_w_s2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner (DB_CYCLES = 4).
//               A reference model predicts pulses, n_out, btn_busy and w_out
//               from sliding windows of synchronised samples; expected pulses
//               go into a queue that a separate monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_conditioner_if ifc ();

    input_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit win_all(input bit q[$], input bit v);
        if (q.size() != DB) return 1'b0;
        foreach (q[i]) if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a level is accepted once the last DB synchronised
    // samples all disagree with the current accepted level.
    // ------------------------------------------------------------------
    bit         m_s1, m_s2, m_w1, m_w2;
    logic [3:0] m_n1, m_n2;
    bit         m_d, m_busy, m_wout;
    logic [3:0] m_nout;
    bit         win_q[$];
    bit         wwin_q[$];
    logic [3:0] exp_q[$];
    bit         t_samp, t_w;
    logic [3:0] t_n;

    always @(posedge clk) begin
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_w1 = 0; m_w2 = 0;
            m_n1 = 0; m_n2 = 0;
            m_d = 0; m_busy = 0; m_wout = 0; m_nout = 0;
            win_q.delete(); wwin_q.delete(); exp_q.delete();
        end else begin
            t_samp = m_s2; t_n = m_n2; t_w = m_w2;
            m_s2 = m_s1; m_s1 = ifc.save_raw;
            m_n2 = m_n1; m_n1 = ifc.n_raw;
            m_w2 = m_w1; m_w1 = ifc.w_raw;

            win_q.push_back(t_samp);
            if (win_q.size() > DB) void'(win_q.pop_front());
            if (win_all(win_q, !m_d)) begin
                m_d = !m_d;
                if (m_d) begin
                    m_nout = t_n;
                    exp_q.push_back(t_n);
                end
            end
            m_busy = m_d | t_samp;
`ifdef INPUT_CONDITIONER_W_DEBOUNCE_EN
            wwin_q.push_back(t_w);
            if (wwin_q.size() > DB) void'(wwin_q.pop_front());
            if (win_all(wwin_q, !m_wout)) m_wout = !m_wout;
`else
            m_wout = m_w2;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic [3:0] e_n;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("save_pulse", int'(ifc.save_pulse), int'(exp_q.size() > 0));
                if (ifc.save_pulse) pulse_cnt++;
                if (exp_q.size() > 0) begin
                    e_n = exp_q.pop_front();
                    if (ifc.save_pulse) chk("n_out_at_pulse", int'(ifc.n_out), int'(e_n));
                end
                chk("btn_busy", int'(ifc.btn_busy), int'(m_busy));
                chk("n_out", int'(ifc.n_out), int'(m_nout));
                chk("w_out", int'(ifc.w_out), int'(m_wout));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_w_out"},      int'(ifc.w_out),      0);
        chk({tag, "_save_pulse"}, int'(ifc.save_pulse), 0);
        chk({tag, "_n_out"},      int'(ifc.n_out),      0);
        chk({tag, "_btn_busy"},   int'(ifc.btn_busy),   0);
    endtask

    int p0, lat, toggles;
    bit prev_busy, seen_high;

    initial begin
        ifc.w_raw = 0; ifc.save_raw = 0; ifc.n_raw = 4'd0;
        rst = 0;
        tick(3);
        chk_reset_outputs("reset");
        rst = 1;
        tick(3);

        // Held press: one pulse, 6 clocks after the raw edge, captures n_raw.
        ifc.n_raw = 4'd9;
        ifc.save_raw = 1;
        p0 = pulse_cnt; lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ifc.save_pulse && lat < 0) lat = i;
        end
        chk("press_latency", lat, 6);
        chk("held_pulses", pulse_cnt - p0, 1);
        chk("n_out_9", int'(ifc.n_out), 9);
        @(negedge clk);
        ifc.save_raw = 0;
        tick(10);

        // Bounce every 2 clocks: no pulse, busy toggles, n_out kept.
        p0 = pulse_cnt; toggles = 0; prev_busy = ifc.btn_busy;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) ifc.save_raw = ~ifc.save_raw;
            ifc.n_raw = 4'(i);
            @(negedge clk);
            if (ifc.btn_busy != prev_busy) toggles++;
            prev_busy = ifc.btn_busy;
        end
        ifc.save_raw = 0;
        tick(10);
        chk("bounce_pulses", pulse_cnt - p0, 0);
        chk("bounce_busy_toggled", int'(toggles >= 4), 1);
        chk("bounce_n_out", int'(ifc.n_out), 9);

        // Release bounce of 2 clocks: single pulse; clean release then press: second.
        p0 = pulse_cnt;
        ifc.n_raw = 4'd2;
        ifc.save_raw = 1; tick(8);
        ifc.save_raw = 0; tick(2);
        ifc.save_raw = 1; tick(8);
        chk("rel_bounce_pulses", pulse_cnt - p0, 1);
        ifc.save_raw = 0; tick(8);
        ifc.n_raw = 4'd12;
        ifc.save_raw = 1; tick(8);
        chk("second_press_pulses", pulse_cnt - p0, 2);
        chk("second_press_n_out", int'(ifc.n_out), 12);
        ifc.save_raw = 0; tick(10);

        // Reset while HELD: outputs clear without a clock, held button re-debounces.
        ifc.n_raw = 4'd5;
        ifc.save_raw = 1; tick(8);
        chk("held_n_out_5", int'(ifc.n_out), 5);
        chk("held_busy", int'(ifc.btn_busy), 1);
        rst = 0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1;
        p0 = pulse_cnt; lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ifc.save_pulse && lat < 0) lat = i;
        end
        chk("post_rst_latency", lat, 6);
        chk("post_rst_pulses", pulse_cnt - p0, 1);
        @(negedge clk);
        ifc.save_raw = 0; tick(10);

        // w path: 3-clock glitch, then a 10-clock level.
        seen_high = 0;
        ifc.w_raw = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) ifc.w_raw = 0;
            @(negedge clk);
            if (ifc.w_out) seen_high = 1;
        end
`ifdef INPUT_CONDITIONER_W_DEBOUNCE_EN
        chk("w_glitch_seen", int'(seen_high), 0);
`else
        chk("w_glitch_seen", int'(seen_high), 1);
`endif
        ifc.w_raw = 1; lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ifc.w_out && lat < 0) lat = i;
        end
`ifdef INPUT_CONDITIONER_W_DEBOUNCE_EN
        chk("w_rise_latency", lat, 6);
`else
        chk("w_rise_latency", lat, 2);
`endif
        @(negedge clk);
        ifc.w_raw = 0; tick(10);

        // Randomised segments with occasional resets.
        for (int seg = 0; seg < 600; seg++) begin
            int len;
            len = int'($urandom_range(1, 9));
            ifc.save_raw = 1'($urandom_range(0, 1));
            ifc.w_raw    = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                ifc.n_raw = 4'($urandom_range(0, 15));
                @(negedge clk);
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 0;
                #1;
                chk_reset_outputs("rand_rst");
                @(negedge clk);
                rst = 1;
            end
        end
        ifc.save_raw = 0; ifc.w_raw = 0;
        tick(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 16, is the number of consecutive stable samples needed to accept a level change (legal range 2..255).
REQ-002 Parameter CNT_W, default 8, is the debounce counter width and SHALL be at least clog2(DB_CYCLES+1).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 w_raw  input  1  raw asynchronous level switch driving the sequence input.
REQ-006 save_raw  input  1  raw asynchronous push-button, high while pressed.
REQ-007 n_raw  input  4  raw asynchronous threshold switches.
REQ-008 w_out  output  1  conditioned level for the downstream n1s/n0s detector.
REQ-009 save_pulse  output  1  single-cycle strobe, one per accepted button press.
REQ-010 n_out  output  4  threshold value captured at the last accepted press.
REQ-011 btn_busy  output  1  high while the button FSM is in any state other than IDLE.

Function
REQ-012 Every raw input SHALL pass through a two-flop synchroniser before any other logic; no raw input SHALL reach combinational output logic.
REQ-013 Button FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; encoding free; all unused encodings SHALL return to IDLE on the next clock.
REQ-014 IDLE: on synchronised save = 1 go to PRESS_WAIT with the counter cleared; otherwise stay.
REQ-015 PRESS_WAIT: counter increments while synchronised save = 1; a 0 sample returns to IDLE with the counter cleared; when the counter reaches DB_CYCLES-1 with save still 1, go to HELD.
REQ-016 Transition PRESS_WAIT->HELD SHALL assert save_pulse for exactly that one clock and load n_out from the synchronised n_raw in the same clock.
REQ-017 HELD: stay while save = 1, no further pulses; on save = 0 go to RELEASE_WAIT with the counter cleared.
REQ-018 RELEASE_WAIT: counter increments while save = 0; a 1 sample returns to HELD; at DB_CYCLES-1 go to IDLE.
REQ-019 Latency: first synchronised-high sample to save_pulse is DB_CYCLES clocks, plus 2 synchroniser clocks from raw input.
REQ-020 Bounce shorter than DB_CYCLES in either direction SHALL NOT produce a pulse; a second pulse needs a full debounced release followed by a full debounced press.
REQ-021 n_out SHALL change only on a save_pulse clock; n_raw changes at other times are ignored.
REQ-022 The counter SHALL saturate and never wrap; a counter compare SHALL never rely on overflow.
REQ-023 w_out path per Configuration; w_out SHALL be glitch-free (registered).

Reset
REQ-024 rst low SHALL immediately, without a clock, force: FSM = IDLE, counters = 0, synchronisers = 0, w_out = 0, save_pulse = 0, n_out = 4'b0000, btn_busy = 0.
REQ-025 Reset asserted mid-press SHALL discard the press; after release, a button already held SHALL go through full PRESS_WAIT debounce before pulsing.
REQ-026 Reset deassertion needs no synchronisation inside the block; the first state change occurs no earlier than the second clock after deassertion.

Configuration
REQ-027 Macro INPUT_CONDITIONER_W_DEBOUNCE_EN defined: w_out is produced by a second debouncer (own counter, same DB_CYCLES) that updates w_out only after DB_CYCLES consecutive equal synchronised samples that differ from w_out.
REQ-028 Macro not defined: w_out equals the synchroniser output (2-clock latency) and the second debouncer is not instantiated.

Verification
REQ-029 DB_CYCLES=4: save_raw held high 20 clocks -> exactly one save_pulse, 6 clocks after the rising edge; n_out = n_raw value at that clock (e.g. 4'd9).
REQ-030 save_raw toggling every 2 clocks for 30 clocks -> no save_pulse, btn_busy toggles, n_out unchanged.
REQ-031 Press, release 2 clocks, re-press (bounce during release) -> single pulse only; clean release >=4 clocks then press -> second pulse.
REQ-032 rst low for 1 clock while in HELD with n_out = 4'd5 -> all outputs 0 asynchronously; button still held after reset -> new pulse after full debounce.
REQ-033 With INPUT_CONDITIONER_W_DEBOUNCE_EN: w_raw 3-clock high glitch -> w_out stays 0; 10-clock high -> w_out rises 6 clocks after edge; without macro: w_out follows w_raw with 2 clocks delay.
